// File: rtl/top_level_modelsim.sv
// ============================================================================
//  Module   : top_level_modelsim
//  Purpose  : Single-cycle 16-bit datapath: 8x16 register file, ALU,
//             immediate operand path and 256x16 data RAM, port-driven control.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_level_modelsim #(
    parameter int DW     = 16,
    parameter int MEM_AW = 8
) (
    input  logic          clock_50,
    input  logic          clear,
    input  logic          WR,
    input  logic          MW,
    input  logic          MA,
    input  logic          MD,
    input  logic          Cin,
    input  logic [2:0]    AA,
    input  logic [2:0]    BA,
    input  logic [2:0]    DA,
    input  logic [4:0]    FS,
    input  logic [DW-1:0] k,
    output logic          Cout,
    output logic          PS,
    output logic          IR_L,
    output logic [DW-1:0] R0,
    output logic [DW-1:0] R1,
    output logic [DW-1:0] R2,
    output logic [DW-1:0] R3,
    output logic [DW-1:0] R4,
    output logic [DW-1:0] R5,
    output logic [DW-1:0] R6,
    output logic [DW-1:0] R7
);

    localparam int c_MEM_DEPTH = 2 ** MEM_AW;

    logic [7:0][DW-1:0] r_regs;
    logic [DW-1:0]      r_mem [c_MEM_DEPTH];

    logic [DW-1:0]     w_a;
    logic [DW-1:0]     w_b;
    logic [DW-1:0]     w_bop;
    logic [DW-1:0]     w_add_b;
    logic              w_add_c;
    logic              w_is_arith;
    logic [DW:0]       w_sum;
    logic [DW-1:0]     w_f;
    logic [DW-1:0]     w_d;
    logic [MEM_AW-1:0] w_addr;
    logic [DW-1:0]     w_mem_dout;

    assign w_a   = r_regs[AA];
    assign w_b   = r_regs[BA];
    assign w_bop = FS[4] ? k : w_b;

    // One shared adder; the op code only picks the second operand and carry.
    always_comb begin
        w_add_b    = '0;
        w_add_c    = 1'b0;
        w_is_arith = 1'b1;
        case (FS[3:0])
            4'h1: begin w_add_b = '0;      w_add_c = 1'b1; end
            4'h2: begin w_add_b = w_bop;   w_add_c = 1'b0; end
            4'h3: begin w_add_b = w_bop;   w_add_c = Cin;  end
            4'h4: begin w_add_b = ~w_bop;  w_add_c = 1'b1; end
            4'h5: begin w_add_b = '1;      w_add_c = 1'b0; end
            4'hD: begin w_add_b = ~w_bop;  w_add_c = Cin;  end
            default: w_is_arith = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_a} + {1'b0, w_add_b} + {{DW{1'b0}}, w_add_c};

    always_comb begin
        w_f = '0;
        case (FS[3:0])
            4'h0:    w_f = w_a;
            4'h6:    w_f = w_a & w_bop;
            4'h7:    w_f = w_a | w_bop;
            4'h8:    w_f = w_a ^ w_bop;
            4'h9:    w_f = ~w_a;
            4'hA:    w_f = {w_a[DW-2:0], 1'b0};
            4'hB:    w_f = {1'b0, w_a[DW-1:1]};
            4'hC:    w_f = w_bop;
            4'hE:    w_f = {w_a[DW-1], w_a[DW-1:1]};
            4'hF:    w_f = '0;
            default: w_f = w_sum[DW-1:0];
        endcase
    end

    assign Cout = w_is_arith & w_sum[DW];
    assign PS   = (w_f == '0);
    assign IR_L = MD & ~WR;

    assign w_addr     = MA ? k[MEM_AW-1:0] : w_a[MEM_AW-1:0];
    assign w_mem_dout = r_mem[w_addr];
    assign w_d        = MD ? w_mem_dout : w_f;

    // RAM has no reset; a low clear only blocks the write.
    always_ff @(posedge clock_50) begin
        if (MW && clear) begin
            r_mem[w_addr] <= w_b;
        end
    end

    always_ff @(posedge clock_50 or negedge clear) begin
        if (!clear) begin
            r_regs <= '0;
        end else if (WR) begin
            r_regs[DA] <= w_d;
        end
    end

    assign R0 = r_regs[0];
    assign R1 = r_regs[1];
    assign R2 = r_regs[2];
    assign R3 = r_regs[3];
    assign R4 = r_regs[4];
    assign R5 = r_regs[5];
    assign R6 = r_regs[6];
    assign R7 = r_regs[7];

endmodule

`default_nettype wire

// File: tb/tb_top_level_modelsim.sv
// ============================================================================
//  Module   : tb_top_level_modelsim
//  Purpose  : Directed and randomized checks of top_level_modelsim against
//             an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top_level_modelsim;

    logic        clock_50;
    logic        clear;
    logic        WR, MW, MA, MD, Cin;
    logic [2:0]  AA, BA, DA;
    logic [4:0]  FS;
    logic [15:0] k;
    logic        Cout, PS, IR_L;
    logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;
    logic [15:0] dut_r [8];

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_regs  [8];
    logic [15:0] m_mem   [256];
    logic        m_valid [256];

    top_level_modelsim #(.DW(16), .MEM_AW(8)) dut (
        .clock_50(clock_50), .clear(clear), .WR(WR), .MW(MW), .MA(MA),
        .MD(MD), .Cin(Cin), .AA(AA), .BA(BA), .DA(DA), .FS(FS), .k(k),
        .Cout(Cout), .PS(PS), .IR_L(IR_L),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7)
    );

    assign dut_r[0] = R0;
    assign dut_r[1] = R1;
    assign dut_r[2] = R2;
    assign dut_r[3] = R3;
    assign dut_r[4] = R4;
    assign dut_r[5] = R5;
    assign dut_r[6] = R6;
    assign dut_r[7] = R7;

    initial begin
        clock_50 = 1'b0;
        forever #5 clock_50 = ~clock_50;
    end

    // Reference ALU written as plain unsigned arithmetic.
    function automatic void model_alu(input logic [4:0] fs, input logic [15:0] a,
                                      input logic [15:0] b, input logic [15:0] kk,
                                      input logic cin, output logic [15:0] f,
                                      output logic cout);
        int unsigned av, bv, cv, r;
        av   = a;
        bv   = fs[4] ? kk : b;
        cv   = cin ? 1 : 0;
        cout = 1'b0;
        r    = 0;
        case (fs[3:0])
            4'h0: r = av;
            4'h1: begin r = av + 1;                cout = (r > 65535); end
            4'h2: begin r = av + bv;               cout = (r > 65535); end
            4'h3: begin r = av + bv + cv;          cout = (r > 65535); end
            4'h4: begin r = av + 65536 - bv;       cout = (av >= bv);  end
            4'h5: begin r = av + 65535;            cout = (av != 0);   end
            4'h6: r = av & bv;
            4'h7: r = av | bv;
            4'h8: r = av ^ bv;
            4'h9: r = 65535 - av;
            4'hA: r = av * 2;
            4'hB: r = av / 2;
            4'hC: r = bv;
            4'hD: begin r = av + (65535 - bv) + cv; cout = (r > 65535); end
            4'hE: r = av / 2 + ((av >= 32768) ? 32768 : 0);
            default: r = 0;
        endcase
        f = 16'(r % 65536);
    endfunction

    task automatic drive(input logic clr, input logic wr, input logic mw,
                         input logic ma, input logic md, input logic cin,
                         input logic [2:0] aa, input logic [2:0] ba,
                         input logic [2:0] da, input logic [4:0] fs,
                         input logic [15:0] kk);
        @(negedge clock_50);
        clear = clr; WR = wr; MW = mw; MA = ma; MD = md; Cin = cin;
        AA = aa; BA = ba; DA = da; FS = fs; k = kk;
        if (!clr) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        end
        #1;
    endtask

    // Advance one edge and apply the architectural effect to the model.
    task automatic tick();
        logic [15:0] f, a, b, d;
        logic        c;
        logic [7:0]  addr;
        a = m_regs[AA];
        b = m_regs[BA];
        model_alu(FS, a, b, k, Cin, f, c);
        addr = MA ? k[7:0] : a[7:0];
        d    = MD ? m_mem[addr] : f;
        @(posedge clock_50);
        if (clear) begin
            if (MW) begin
                m_mem[addr]   = b;
                m_valid[addr] = 1'b1;
            end
            if (WR) m_regs[DA] = d;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd3, 5'b11100, 16'hBEEF);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_r[i] !== 16'h0000) begin
                failures++;
                $display("FAIL reset_async R%0d got=%h exp=0000", i, dut_r[i]);
            end
        end
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_r[i] !== 16'h0000) begin
                failures++;
                $display("FAIL reset_hold R%0d got=%h exp=0000", i, dut_r[i]);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd5, 5'b11100, 16'hABCD);
        tick();
        checks++;
        if (R5 !== 16'hABCD) begin
            failures++;
            $display("FAIL reset_release R5 got=%h exp=abcd", R5);
        end
    endtask

    task automatic test_load_imm();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 5'b11100, 16'h1234);
        tick();
        checks++;
        if (R1 !== 16'h1234) begin
            failures++;
            $display("FAIL load_r1 got=%h exp=1234", R1);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd2, 5'b11100, 16'hFFFF);
        tick();
        checks++;
        if (R2 !== 16'hFFFF) begin
            failures++;
            $display("FAIL load_r2 got=%h exp=ffff", R2);
        end
    endtask

    task automatic test_arith();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 3'd3, 5'b00001, 16'h0000);
        checks++;
        if (Cout !== 1'b1 || PS !== 1'b1) begin
            failures++;
            $display("FAIL inc_wrap cout/ps got=%b%b exp=11", Cout, PS);
        end
        tick();
        checks++;
        if (R3 !== 16'h0000) begin
            failures++;
            $display("FAIL inc_wrap R3 got=%h exp=0000", R3);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd2, 3'd6, 5'b00100, 16'h0000);
        checks++;
        if (Cout !== 1'b0 || PS !== 1'b0) begin
            failures++;
            $display("FAIL sub cout/ps got=%b%b exp=00", Cout, PS);
        end
        tick();
        checks++;
        if (R6 !== 16'h1235) begin
            failures++;
            $display("FAIL sub R6 got=%h exp=1235", R6);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 3'd0, 5'b00101, 16'h0000);
        checks++;
        if (Cout !== 1'b0) begin
            failures++;
            $display("FAIL dec_zero cout got=%b exp=0", Cout);
        end
        tick();
    endtask

    task automatic test_memory();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'd0, 5'b00000, 16'h0010);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd4, 5'b00000, 16'h0010);
        checks++;
        if (IR_L !== 1'b0) begin
            failures++;
            $display("FAIL irl_low got=%b exp=0", IR_L);
        end
        tick();
        checks++;
        if (R4 !== 16'h1234) begin
            failures++;
            $display("FAIL mem_load R4 got=%h exp=1234", R4);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd4, 5'b00000, 16'h0010);
        checks++;
        if (IR_L !== 1'b1) begin
            failures++;
            $display("FAIL irl_high got=%b exp=1", IR_L);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_r[i] !== m_regs[i]) begin
                failures++;
                $display("FAIL irl_nowrite R%0d got=%h exp=%h", i, dut_r[i], m_regs[i]);
            end
        end
    endtask

    task automatic test_logic_shift();
        logic [4:0]  fs_list [4] = '{5'b01010, 5'b01110, 5'b01001, 5'b01111};
        logic [2:0]  aa_list [4] = '{3'd1, 3'd2, 3'd1, 3'd1};
        logic [15:0] exp_list[4] = '{16'h2468, 16'hFFFF, 16'hEDCB, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, aa_list[i], 3'd0, 3'd7, fs_list[i], 16'h0000);
            checks++;
            if (PS !== (exp_list[i] == 16'h0000) || Cout !== 1'b0) begin
                failures++;
                $display("FAIL logic%0d ps/cout got=%b%b", i, PS, Cout);
            end
            tick();
            checks++;
            if (R7 !== exp_list[i]) begin
                failures++;
                $display("FAIL logic%0d R7 got=%h exp=%h", i, R7, exp_list[i]);
            end
        end
    endtask

    task automatic test_carry_in();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd3, 3'd5, 5'b00011, 16'h0000);
        tick();
        checks++;
        if (R5 !== 16'h1235) begin
            failures++;
            $display("FAIL cin1 R5 got=%h exp=1235", R5);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd3, 3'd5, 5'b00011, 16'h0000);
        tick();
        checks++;
        if (R5 !== 16'h1234) begin
            failures++;
            $display("FAIL cin0 R5 got=%h exp=1234", R5);
        end
    endtask

    task automatic test_reset_midop();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 3'd1, 5'b11100, 16'h0010);
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_r[i] !== 16'h0000) begin
                failures++;
                $display("FAIL midop_reset R%0d got=%h exp=0000", i, dut_r[i]);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 5'b00000, 16'h0010);
        tick();
        checks++;
        if (R0 !== 16'h1234) begin
            failures++;
            $display("FAIL midop_mem_kept R0 got=%h exp=1234", R0);
        end
    endtask

    task automatic test_random();
        logic        clr, wr, mw, ma, md, cin;
        logic [2:0]  aa, ba, da;
        logic [4:0]  fs;
        logic [15:0] kk, f;
        logic [7:0]  addr;
        logic        c;
        for (int n = 0; n < 300; n++) begin
            clr = ($urandom_range(0, 19) != 0);
            wr  = 1'($urandom_range(0, 1));
            mw  = 1'($urandom_range(0, 1));
            ma  = 1'($urandom_range(0, 1));
            md  = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            aa  = 3'($urandom_range(0, 7));
            ba  = 3'($urandom_range(0, 7));
            da  = 3'($urandom_range(0, 7));
            fs  = 5'($urandom_range(0, 31));
            kk  = 16'($urandom_range(0, 65535));
            if (!clr) aa = 3'd0;
            addr = ma ? kk[7:0] : (clr ? m_regs[aa][7:0] : 8'h00);
            if (!m_valid[addr]) md = 1'b0;
            drive(clr, wr, mw, ma, md, cin, aa, ba, da, fs, kk);
            model_alu(fs, m_regs[aa], m_regs[ba], kk, cin, f, c);
            checks++;
            if (Cout !== c || PS !== (f == 16'h0000) || IR_L !== (md & ~wr)) begin
                failures++;
                $display("FAIL rand%0d fs=%b cout/ps/irl got=%b%b%b exp=%b%b%b",
                         n, fs, Cout, PS, IR_L, c, (f == 16'h0000), (md & ~wr));
            end
            tick();
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (dut_r[i] !== m_regs[i]) begin
                    failures++;
                    $display("FAIL rand%0d R%0d got=%h exp=%h", n, i, dut_r[i], m_regs[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_mem[i]   = 16'h0000;
            m_valid[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        clear = 1'b1; WR = 1'b0; MW = 1'b0; MA = 1'b0; MD = 1'b0; Cin = 1'b0;
        AA = 3'd0; BA = 3'd0; DA = 3'd0; FS = 5'd0; k = 16'h0000;
        test_reset();
        test_load_imm();
        test_arith();
        test_memory();
        test_logic_shift();
        test_carry_in();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/top_level_modelsim.md
Name: top_level_modelsim

Overview:
- Single-cycle 16-bit processor datapath for simulation.
- Contains an 8×16 register file, a 16-bit ALU, an immediate operand path, and a 256×16 data RAM.
- All control words (register addresses, function select, mux selects, write enables) come straight from ports, so a bench or a later control unit can drive it.
- Register contents are exported for observation.

Parameters:
- DW, 16, data/register width
- MEM_AW, 8, data-RAM address width (256 words)

Ports:
- clock_50 input 1: system clock, rising-edge active
- clear input 1: asynchronous active-low reset
- WR input 1: register-file write enable
- MW input 1: memory write enable
- MA input 1: memory address select (0 = A bus, 1 = k)
- MD input 1: D-bus select (0 = ALU F, 1 = memory data out)
- Cin input 1: ALU carry in
- AA input 3: A-bus register address
- BA input 3: B-bus register address
- DA input 3: destination register address
- FS input 5: function select; FS[4]=1 replaces B with k
- k input 16: immediate constant
- Cout output 1: ALU carry out
- PS output 1: zero status, 1 when ALU F == 16'h0000
- IR_L output 1: instruction-load request, MD & ~WR
- R0..R7 output 16 each: live register-file contents

Behaviour:
- Reset: clear low immediately forces R0..R7 to 0. This is asynchronous and independent of the clock, and holds while low. The RAM is not reset.
- Buses (combinational): A = R[AA]; B = R[BA]; Bop = FS[4] ? k : B.
- ALU ops on FS[3:0], 17-bit internal sum for carry:
  - 0: F=A
  - 1: A+1
  - 2: A+Bop
  - 3: A+Bop+Cin
  - 4: A+~Bop+1
  - 5: A−1 (A+16'hFFFF)
  - 6: A&Bop
  - 7: A|Bop
  - 8: A^Bop
  - 9: ~A
  - A: A<<1
  - B: A>>1 logical
  - C: Bop
  - D: A+~Bop+Cin
  - E: A>>>1 arithmetic
  - F: 0
- Cout: bit 16 of the sum for codes 1–5 and D. Cout=1 for code 5 unless A==0. Cout is 0 for all other codes.
- Cin affects only codes 3 and D.
- Wrap-around: results are modulo 2^16. For example, FFFF+1 = 0000 with Cout=1.
- Memory address: MA ? k[7:0] : A[7:0]. Upper address bits are ignored.
- Memory read is asynchronous and combinational.
- Memory write: on the rising clock edge, when MW=1 and clear=1, mem[addr] <= B. The data written is always register B, never k.
- D bus: MD ? mem_dout : F.
- Register write: on the rising clock edge, when WR=1 and clear=1, R[DA] <= D.
- Same-cycle read/write: MW and WR in the same cycle are both performed. D uses the pre-edge memory value.
- Reading a register being written gives the old value until the edge, then the new value.
- Reset mid-operation: clear low overrides WR in that cycle. An MW write in the same cycle is also suppressed.
- PS, IR_L and Cout are purely combinational with zero latency.
- R0..R7 update one edge after the write.
- R0 is an ordinary writable register, not hardwired to zero.

Test Plan:
- Reset: clear=0 with WR=1, arbitrary DA/k → R0..R7 all 0000 and remain 0; release clear → writes resume on the next edge.
- Load immediates: FS=5'b11100, k=0x1234, DA=1, WR=1, MD=0 → R1=1234 after the edge. Repeat with k=0xFFFF into R2 → R2=FFFF.
- Arithmetic: AA=2, FS=00001 → F=0000, Cout=1, PS=1. Write to R3 → R3=0000. FS=00100 with AA=1, BA=2 → 1234−FFFF = 1235, Cout=0.
- Memory: MA=1, k=0x0010, BA=1, MW=1 → mem[0x10]=1234. Next cycle MD=1, WR=1, DA=4 → R4=1234, IR_L=0. With MD=1, WR=0 → IR_L=1 and no register changes.
- Logic/shift: R1=1234, FS=01010 → F=2468. FS=01110 on R2=FFFF → F=FFFF. FS=01001 on R1 → EDCB. FS=01111 → F=0, PS=1.
- Carry-in: FS=00011 with R1=1234, R3=0000, Cin=1 → F=1235. Cin=0 → 1234.
